seg7_scan_display: RTL and testbench

- Parametrised, fully synchronous successor to the 8-digit multiplexed 7-segment driver on the FPGA board.
- Displays N_FIELDS unsigned binary values, each on DIGITS_PER_FIELD decimal digits.
- Uses one shared sequential binary-to-BCD converter instead of per-field dividers.
- Adds leading-zero suppression, an overflow indication, per-digit blank and decimal-point masks, brightness PWM, and a frame strobe.
- Sits between game/score logic and the board's CA..CG/DP/AN pins.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_bin2bcd.sv | 75 +++++++
 rtl/seg7_scan_display.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_display.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, constant helpers and converter states for seg7_scan_display
package seg7_pkg;

  // Active-low {CA..CG} patterns
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // ceil(log2(n)), never less than 1 so it can size a register
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // BCD nibble to pattern; 10..15 never come out of the converter and stay dark
  function automatic logic [6:0] seg_of_nibble(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0: r = SEG_0;
      4'd1: r = SEG_1;
      4'd2: r = SEG_2;
      4'd3: r = SEG_3;
      4'd4: r = SEG_4;
      4'd5: r = SEG_5;
      4'd6: r = SEG_6;
      4'd7: r = SEG_7;
      4'd8: r = SEG_8;
      4'd9: r = SEG_9;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// rtl/seg7_bin2bcd.sv - sequential double-dabble binary to BCD converter with overflow flag
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int BIN_W = 32,
  parameter int N_BCD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     value,
  output logic                 done,
  output logic [4*N_BCD-1:0]   bcd,
  output logic                 ovf
);

  localparam int CNT_W = clog2(BIN_W);
  localparam logic [63:0] LIMIT = pow10(N_BCD) - 64'd1;

  conv_state_t        state;
  logic [BIN_W-1:0]   bin_q;
  logic [4*N_BCD-1:0] bcd_q;
  logic [4*N_BCD-1:0] bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;
  logic               done_q;

  // add-3 correction on every nibble of 5 or more before the next shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N_BCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // IDLE -> LOAD -> SHIFT (BIN_W cycles) -> STORE -> LOAD ...; done is high during STORE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          bin_q <= value;
          bcd_q <= '0;
          cnt   <= '0;
          ovf_q <= {{64{1'b0}}, value} > {{BIN_W{1'b0}}, LIMIT};
          state <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[4*N_BCD-2:0], bin_q[BIN_W-1]};
          bin_q <= bin_q << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state  <= STORE;
            done_q <= 1'b1;
          end
        end
        STORE: state <= start ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed 7-segment driver with shared BCD converter, PWM and masks
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ           = 50_000_000,
  parameter int REFRESH_HZ       = 1000,
  parameter int N_FIELDS         = 3,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int BIN_W            = 32,
  parameter int LZ_SUPPRESS      = 1
) (
  input  logic                                   CLK50MHZ,
  input  logic                                   RESETN,
  input  logic [N_FIELDS*BIN_W-1:0]              values,
  input  logic [N_FIELDS*DIGITS_PER_FIELD-1:0]   blank_mask,
  input  logic [N_FIELDS*DIGITS_PER_FIELD-1:0]   dp_mask,
  input  logic [2:0]                             brightness,
  output logic [6:0]                             SEG,
  output logic                                   DP,
  output logic [N_FIELDS*DIGITS_PER_FIELD-1:0]   AN,
  output logic                                   frame_done
);

  localparam int ND    = N_FIELDS * DIGITS_PER_FIELD;
  localparam int DIV   = CLK_HZ / (REFRESH_HZ * ND);
  localparam int CNT_W = clog2(DIV);
  localparam int IDX_W = clog2(ND);
  localparam int FLD_W = clog2(N_FIELDS);
  localparam int PW    = CNT_W + 4;

  if (DIV < 8) begin : g_div_check
    $error("seg7_scan_display: slot divider must be at least 8");
  end

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [2:0]       bright_q;
  logic             slot_end;
  logic [PW-1:0]    on_prod;
  logic             lit;

  assign slot_end = (cnt == CNT_W'(DIV - 1));

  // slot counter, digit index and brightness snapshot taken at slot start
  always_ff @(posedge CLK50MHZ or negedge RESETN) begin
    if (!RESETN) begin
      cnt      <= '0;
      idx      <= '0;
      bright_q <= '0;
    end else begin
      if (cnt == '0) bright_q <= brightness;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(ND - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // cnt < ((b+1)*DIV)>>3 rewritten as 8*(cnt+1) <= (b+1)*DIV; true at cnt 0 for any b since DIV >= 8
  assign on_prod = (PW'(bright_q) + PW'(1)) * PW'(DIV);
  assign lit     = (PW'({cnt, 3'b000}) + PW'(8)) <= on_prod;

  logic [FLD_W-1:0]              fld;
  logic                          conv_done;
  logic                          conv_ovf;
  logic [4*DIGITS_PER_FIELD-1:0] conv_bcd;
  logic [BIN_W-1:0]              conv_value;

  assign conv_value = values[int'(fld)*BIN_W +: BIN_W];

  seg7_bin2bcd #(
    .BIN_W (BIN_W),
    .N_BCD (DIGITS_PER_FIELD)
  ) u_bin2bcd (
    .clk   (CLK50MHZ),
    .rst_n (RESETN),
    .start (1'b1),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  logic [3:0]          nib [ND];
  logic [N_FIELDS-1:0] ovf_f;

  // digit store: a field's nibbles and overflow flag are replaced together; 4'hF marks "nothing yet"
  always_ff @(posedge CLK50MHZ or negedge RESETN) begin
    if (!RESETN) begin
      fld   <= '0;
      ovf_f <= '0;
      for (int i = 0; i < ND; i++) nib[i] <= 4'hF;
    end else if (conv_done) begin
      for (int j = 0; j < DIGITS_PER_FIELD; j++)
        nib[IDX_W'(int'(fld) * DIGITS_PER_FIELD + j)] <= conv_bcd[4*j +: 4];
      ovf_f[fld] <= conv_ovf;
      fld <= (fld == FLD_W'(N_FIELDS - 1)) ? '0 : fld + FLD_W'(1);
    end
  end

  logic [ND-1:0] lz_dark;
  logic [ND-1:0] ovf_d;
  logic          run;

  // a digit is a leading zero when it and every higher digit of its field is zero (LSD excluded)
  always_comb begin
    lz_dark = '0;
    ovf_d   = '0;
    run     = 1'b0;
    for (int f = 0; f < N_FIELDS; f++) begin
      run = 1'b1;
      for (int j = DIGITS_PER_FIELD - 1; j >= 0; j--) begin
        run = run && (nib[f*DIGITS_PER_FIELD + j] == 4'd0);
        lz_dark[f*DIGITS_PER_FIELD + j] = run && (j != 0) && (LZ_SUPPRESS != 0);
        ovf_d[f*DIGITS_PER_FIELD + j]   = ovf_f[f];
      end
    end
  end

  logic [6:0] digit_seg;

  // pattern for the current digit: blank mask, then overflow dash, then leading zero, then number
  always_comb begin
    if (blank_mask[idx])   digit_seg = SEG_BLANK;
    else if (ovf_d[idx])   digit_seg = SEG_DASH;
    else if (lz_dark[idx]) digit_seg = SEG_BLANK;
    else                   digit_seg = seg_of_nibble(nib[idx]);
  end

  // registered pin drivers; segments and DP go dark whenever no anode is driven
  always_ff @(posedge CLK50MHZ or negedge RESETN) begin
    if (!RESETN) begin
      SEG        <= SEG_BLANK;
      DP         <= 1'b1;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_end && (idx == IDX_W'(ND - 1));
      if (lit) begin
        AN  <= ~(ND'(1) << idx);
        SEG <= digit_seg;
        DP  <= ~dp_mask[idx];
      end else begin
        AN  <= '1;
        SEG <= SEG_BLANK;
        DP  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - randomized and directed bench for seg7_scan_display with a behavioural model
module tb_seg7_scan_display;

  localparam int ND    = 6;
  localparam int DIV   = 13;
  localparam int FRAME = 78;
  localparam int CONV  = 34;
  localparam int NF    = 3;
  localparam int SETTLE = 3 * CONV + 2 + FRAME;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] values = '0;
  logic [5:0]  blank_mask = '0;
  logic [5:0]  dp_mask = '0;
  logic [2:0]  brightness = 3'd7;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_done;

  seg7_scan_display #(
    .CLK_HZ     (8000),
    .REFRESH_HZ (100)
  ) dut (
    .CLK50MHZ   (clk),
    .RESETN     (rst_n),
    .values     (values),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .brightness (brightness),
    .SEG        (seg),
    .DP         (dp),
    .AN         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [6:0] pattern(input int n);
    case (n)
      0: pattern = 7'b0000001;
      1: pattern = 7'b1001111;
      2: pattern = 7'b0010010;
      3: pattern = 7'b0000110;
      4: pattern = 7'b1001100;
      5: pattern = 7'b0100100;
      6: pattern = 7'b0100000;
      7: pattern = 7'b0001111;
      8: pattern = 7'b0000000;
      9: pattern = 7'b0001100;
      default: pattern = 7'b1111111;
    endcase
  endfunction

  // what digit j (0 = units) of a two-digit field holding v must look like
  function automatic logic [6:0] field_digit_seg(input longint unsigned v, input int j);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < j; k++) p = p * 10;
    if (v > 99) return 7'b1111110;
    if (j > 0 && v < p) return 7'b1111111;
    return pattern(int'((v / p) % 10));
  endfunction

  function automatic int on_time(input int b);
    return ((b + 1) * DIV) >> 3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // behavioural model: edge count since reset release drives slot position and conversion schedule
  int              e = 0;
  int              mb = 0;
  longint unsigned snap = 0;
  longint unsigned mval [NF];
  bit              mvalid [NF];
  logic [6:0]      exp_seg = 7'h7F;
  logic            exp_dp = 1'b1;
  logic [5:0]      exp_an = 6'h3F;
  logic            exp_fd = 1'b0;
  bit              cmp_en = 1'b0;

  initial begin
    int p, c, d, f, j;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0;
        for (int k = 0; k < NF; k++) mvalid[k] = 1'b0;
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 6'h3F; exp_fd = 1'b0;
      end else begin
        e++;
        p = e - 1;
        c = p % DIV;
        d = (p / DIV) % ND;
        f = d / 2;
        j = d % 2;
        if (c == 0) mb = int'(brightness);
        exp_fd = ((p % FRAME) == FRAME - 1);
        if (c < on_time(mb)) begin
          exp_an = ~(6'd1 << d);
          exp_dp = ~dp_mask[d];
          if (blank_mask[d] || !mvalid[f]) exp_seg = 7'h7F;
          else exp_seg = field_digit_seg(mval[f], j);
        end else begin
          exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1;
        end
        if (e >= 2 && (e - 2) % CONV == 0) snap = values[(((e - 2) / CONV) % NF) * 32 +: 32];
        if (e >= 35 && (e - 35) % CONV == 0) begin
          mval[((e - 35) / CONV) % NF] = snap;
          mvalid[((e - 35) / CONV) % NF] = 1'b1;
        end
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checks++;
        if (seg !== exp_seg || dp !== exp_dp || an !== exp_an || frame_done !== exp_fd) begin
          failures++;
          $display("FAIL model_cmp t=%0t e=%0d: got seg=%b dp=%b an=%b fd=%b, expected seg=%b dp=%b an=%b fd=%b",
                   $time, e, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
        end
      end
    end
  end

  // waits for digit d to be driven and returns its segments and DP
  task automatic grab(input int d, output logic [6:0] s, output logic p);
    int n;
    logic [5:0] want_an;
    want_an = ~(6'd1 << d);
    n = 0;
    @(negedge clk);
    while (an !== want_an && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL grab_timeout digit=%0d an=%b", d, an);
    end
    s = seg;
    p = dp;
  endtask

  task automatic settle();
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  task automatic pre_conversion_dark();
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      check("dark_before_first_conversion", seg, 7'h7F);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] s;
    logic       p;
    int         n;
    int         lit_cnt;
    int         ghost;
    logic [6:0] t1_exp [ND];
    logic [6:0] t2_exp [ND];

    t1_exp = '{7'b0001100, 7'b0001100, 7'b0001111, 7'b1111111, 7'b0100100, 7'b1001100};
    t2_exp = '{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b0000001, 7'b1111111};

    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_an", an, 6'h3F);
    check("reset_frame_done", frame_done, 1'b0);

    check("model_pin_45_tens", field_digit_seg(45, 1), 7'b1001100);
    check("model_pin_7_tens_dark", field_digit_seg(7, 1), 7'b1111111);
    check("model_pin_100_dash", field_digit_seg(100, 0), 7'b1111110);
    check("model_pin_on_time_b1", on_time(1), 3);
    check("model_pin_on_time_b7", on_time(7), 13);

    // values and full brightness
    values = {32'd45, 32'd7, 32'd99};
    @(negedge clk); #2 rst_n = 1'b1;
    pre_conversion_dark();
    settle();
    for (int d = 0; d < ND; d++) begin
      grab(d, s, p);
      check($sformatf("t1_digit%0d", d), s, t1_exp[d]);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 200);
    check("frame_done_period", n, FRAME);

    // overflow and zero boundaries
    @(posedge clk); #1;
    values = {32'd0, 32'hFFFF_FFFF, 32'd100};
    settle();
    for (int d = 0; d < ND; d++) begin
      grab(d, s, p);
      check($sformatf("t2_digit%0d", d), s, t2_exp[d]);
    end

    // brightness 1: 3 of 13 cycles lit per slot, dark segments while no anode is driven
    brightness = 3'd1;
    repeat (2 * FRAME) @(posedge clk);
    lit_cnt = 0;
    ghost = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an !== 6'h3F) lit_cnt++;
      else if (seg !== 7'h7F) ghost++;
    end
    check("pwm_lit_cycles_per_frame", lit_cnt, 6 * 3);
    check("pwm_ghost_cycles", ghost, 0);

    // blank and decimal-point masks
    @(posedge clk); #1;
    brightness = 3'd7;
    values = {32'd45, 32'd7, 32'd99};
    blank_mask = 6'b000100;
    dp_mask = 6'b000001;
    settle();
    grab(2, s, p);
    check("t4_digit2_blank", s, 7'h7F);
    grab(0, s, p);
    check("t4_digit0_seg", s, 7'b0001100);
    check("t4_digit0_dp", p, 1'b0);
    grab(1, s, p);
    check("t4_digit1_dp", p, 1'b1);

    // atomic field update 12 -> 34
    @(posedge clk); #1;
    blank_mask = '0;
    dp_mask = '0;
    values = {32'd45, 32'd7, 32'd12};
    settle();
    grab(0, s, p);
    check("t5_before_units", s, 7'b0010010);
    grab(1, s, p);
    check("t5_before_tens", s, 7'b1001111);
    @(posedge clk); #1;
    values[31:0] = 32'd34;
    settle();
    grab(0, s, p);
    check("t5_after_units", s, 7'b1001100);
    grab(1, s, p);
    check("t5_after_tens", s, 7'b0000110);

    // asynchronous reset in the middle of a shift and of a slot
    n = 0;
    do begin @(posedge clk); #1; n++; end while (((e - 2) % CONV) != 15 && n < 100);
    check("t6_reach_mid_shift", ((e - 2) % CONV), 15);
    check("t6_lit_before_reset", (an !== 6'h3F), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_seg", seg, 7'h7F);
    check("t6_async_an", an, 6'h3F);
    check("t6_async_dp", dp, 1'b1);
    check("t6_async_fd", frame_done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    pre_conversion_dark();
    settle();
    grab(4, s, p);
    check("t6_after_reset_digit4", s, 7'b0100100);

    // randomized values, masks and brightness, some values changing during conversions
    for (int r = 0; r < 12; r++) begin
      for (int f = 0; f < NF; f++) begin
        int m;
        logic [31:0] v;
        m = $urandom_range(0, 3);
        case (m)
          0: v = $urandom_range(0, 9);
          1: v = $urandom_range(0, 120);
          2: v = $urandom;
          default: v = (f == 0) ? 32'd99 : ((f == 1) ? 32'd100 : 32'd0);
        endcase
        values[f*32 +: 32] = v;
      end
      blank_mask = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      dp_mask = 6'($urandom_range(0, 63));
      brightness = 3'($urandom_range(0, 7));
      repeat ($urandom_range(20, 250)) @(posedge clk);
      #1;
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
